// File: rtl/matmul_operand_sequencer_pkg.sv
// matmul_operand_sequencer_pkg: shared default parameters and FSM state encoding
package matmul_operand_sequencer_pkg;
    localparam int NBITS = 4;
    localparam int NDATA = 4;
    localparam int LATENCY = 3;
    localparam int N = NDATA;
    localparam int IDXW = $clog2(NDATA);
    localparam int ADDRW = 2 * IDXW;
    localparam int RESW = 2 * NBITS;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, DONE} state_t;
endpackage

// File: rtl/matmul_operand_store.sv
// matmul_operand_store: NxN element array with one write port and a row (or column) read view.
// Reads see a write landing at the same edge, so a load issued alongside start reaches the first launch.
module matmul_operand_store
    import matmul_operand_sequencer_pkg::*;
#(
    parameter int Nbits = NBITS,
    parameter int Ndata = NDATA,
    parameter bit COL = 1'b0,
    localparam int IW = $clog2(Ndata),
    localparam int AW = 2 * IW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [AW-1:0]          addr,
    input  logic [Nbits-1:0]       data,
    input  logic [IW-1:0]          idx,
    output logic [Ndata*Nbits-1:0] view
);
    logic [Nbits-1:0] mem [Ndata*Ndata];
    logic [Nbits-1:0] nxt [Ndata*Ndata];

    always_comb begin
        nxt = mem;
        if (we) nxt[addr] = data;
    end

    always_ff @(posedge clk) begin
        if (reset) mem <= '{default: '0};
        else mem <= nxt;
    end

    for (genvar k = 0; k < Ndata; k++) begin : g_view
        assign view[k*Nbits +: Nbits] = COL ? nxt[{IW'(k), idx}] : nxt[{idx, IW'(k)}];
    end
endmodule

// File: rtl/matmul_operand_sequencer.sv
// matmul_operand_sequencer: walks every (i,j) of C = A*B, launching row i of A and column j of B
// to the scalar-product engine and streaming each captured result out over valid/ready.
module matmul_operand_sequencer
    import matmul_operand_sequencer_pkg::*;
#(
    parameter int Nbits = NBITS,
    parameter int Ndata = NDATA,
    parameter int LAT = LATENCY,
    localparam int IW = $clog2(Ndata),
    localparam int AW = 2 * IW,
    localparam int RW = 2 * Nbits,
    localparam int BW = Ndata * Nbits
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic             ld_sel,
    input  logic [AW-1:0]    ld_addr,
    input  logic [Nbits-1:0] ld_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [BW-1:0]    sp_A,
    output logic [BW-1:0]    sp_B,
    output logic             sp_valid,
    input  logic [RW-1:0]    sp_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RW-1:0]    res_data,
    output logic [IW-1:0]    res_row,
    output logic [IW-1:0]    res_col
);
    localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
    localparam logic [IW-1:0] LAST = IW'(Ndata - 1);

    state_t state, nxt;
    logic [IW-1:0] i, j, i_nxt, j_nxt;
    logic [CW-1:0] cnt;
    logic [BW-1:0] a_row, b_col;
    logic hs, last;

    matmul_operand_store #(.Nbits(Nbits), .Ndata(Ndata), .COL(1'b0)) u_a (
        .clk(clk),
        .reset(reset),
        .we(ld_valid && ld_ready && !ld_sel),
        .addr(ld_addr),
        .data(ld_data),
        .idx(i_nxt),
        .view(a_row)
    );

    matmul_operand_store #(.Nbits(Nbits), .Ndata(Ndata), .COL(1'b1)) u_b (
        .clk(clk),
        .reset(reset),
        .we(ld_valid && ld_ready && ld_sel),
        .addr(ld_addr),
        .data(ld_data),
        .idx(j_nxt),
        .view(b_col)
    );

    assign hs = res_valid && res_ready;
    assign last = (i == LAST) && (j == LAST);

    // Index of the next launch; the stores are read here so sp_A/sp_B register on entry to ISSUE.
    assign j_nxt = state == IDLE ? '0 : (state == EMIT && hs) ? j + 1'b1 : j;
    assign i_nxt = state == IDLE ? '0 : (state == EMIT && hs && j == LAST) ? i + 1'b1 : i;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? ISSUE : IDLE;
            ISSUE:   nxt = WAIT;
            WAIT:    nxt = cnt == '0 ? EMIT : WAIT;
            EMIT:    nxt = !hs ? EMIT : last ? DONE : ISSUE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_ready = state == IDLE;
        busy = state != IDLE;
        done = state == DONE;
        sp_valid = state == ISSUE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i <= '0;
            j <= '0;
            cnt <= '0;
            sp_A <= '0;
            sp_B <= '0;
            res_valid <= 1'b0;
            res_data <= '0;
            res_row <= '0;
            res_col <= '0;
        end else begin
            i <= i_nxt;
            j <= j_nxt;
            cnt <= state == ISSUE ? CW'(LAT - 1) : (state == WAIT && cnt != '0) ? cnt - 1'b1 : cnt;
            if (nxt == ISSUE) begin
                sp_A <= a_row;
                sp_B <= b_col;
            end
            if (state == WAIT && cnt == '0) begin
                res_valid <= 1'b1;
                res_data <= sp_result;
                res_row <= i;
                res_col <= j;
            end else if (hs) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/matmul_operand_sequencer.md
Name: matmul_operand_sequencer

Overview:
Initiator side of the scalar-product engine interface. It stores two NxN operand matrices (N = Ndata), each loaded element-by-element. On start it drives the engine's flat A/B buses with row i of A and column j of B for every (i,j) in row-major order. It samples the engine result after a fixed latency and streams each C[i][j] out over a valid/ready port.

Parameters:
Nbits, 4, element width in bits
Ndata, 4, vector length = matrix dimension N; power of two
LAT, 3, cycles from operand launch to valid engine result (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
ld_valid  in  1  element write request
ld_ready  out  1  element write accepted (high only in IDLE)
ld_sel  in  1  0 = matrix A, 1 = matrix B
ld_addr  in  2*log2(Ndata)  row*Ndata+col
ld_data  in  Nbits  element value
start  in  1  begin full product (IDLE only)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after last result handshake
sp_A  out  Ndata*Nbits  row i of A; element k at [(k+1)*Nbits-1:k*Nbits]
sp_B  out  Ndata*Nbits  column j of B; element k = B[k][j], same packing
sp_valid  out  1  one-cycle launch strobe for the engine
sp_result  in  2*Nbits  engine dot product
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_data  out  2*Nbits  C[i][j]
res_row  out  log2(Ndata)  i
res_col  out  log2(Ndata)  j

Behaviour:
- Reset: state IDLE; ld_ready=1; busy, done, sp_valid, res_valid = 0; sp_A, sp_B, res_data, res_row, res_col = 0; both matrix stores cleared to 0; i=j=0; wait counter = 0.
- Load: a write occurs on a cycle with ld_valid && ld_ready. The element is written at that clock edge. Writes in other states are dropped (ld_ready=0).
- States:
  - IDLE: if start, go to ISSUE with i=j=0. A load and start in the same cycle are both accepted; ISSUE reads the updated store.
  - ISSUE (1 cycle): sp_A/sp_B registered from the stores; sp_valid=1; go to WAIT and load the counter with LAT-1.
  - WAIT: sp_A/sp_B held stable; sp_valid=0. When the counter reaches 0, capture sp_result into res_data with res_row=i and res_col=j, set res_valid=1, and go to EMIT. For LAT=1 the capture happens in the first WAIT cycle.
  - EMIT: res_valid and all res_* fields are held until res_ready. On handshake, res_valid drops the next cycle.
    - If (i,j) = (N-1,N-1): go to DONE.
    - Otherwise advance j; on wrap, j=0 and i++. Then go to ISSUE.
  - DONE (1 cycle): done=1; go to IDLE.
- Timing: start at cycle t gives sp_valid at t+1 and capture at t+1+LAT. Without backpressure each result costs LAT+2 cycles. A full run takes N*N*(LAT+2)+1 cycles from start to the done pulse.
- Arithmetic: the sequencer does no arithmetic on data. sp_result is taken as-is, i.e. modulo 2^(2*Nbits), matching the engine's truncating sum.
- Boundary conditions:
  - start while busy is ignored.
  - res_ready high outside EMIT has no effect.
  - Only one launch is outstanding at a time; no sp_valid while EMIT is stalled.
  - Reset mid-run aborts immediately to the reset state; any pending result is discarded and the stores are cleared.
  - Stores are not modified by a run, so a second start reproduces identical results.

Decomposition:
- Shared package: localparams N=Ndata, IDXW=log2(Ndata), ADDRW=2*IDXW, RESW=2*Nbits; state enum IDLE/ISSUE/WAIT/EMIT/DONE.
- One natural sub-module: matmul_operand_store. It holds an NxN register array with a write port and two read views: the full row bus for index r, and the full column bus for index c. It is instantiated once each for A (row view) and B (column view).

Test Plan:
1. A = identity, B[r][c] = 4r+c. Start with res_ready tied high → 16 results in order (0,0)…(3,3) with res_data = 0,1,…,15. done pulses exactly once, 16*(LAT+2)+1 = 81 cycles after start.
2. All A and B elements = 15 → every res_data = 4*225 mod 256 = 132 (overflow wrap).
3. res_ready held low for 5 cycles on the first result → res_valid, res_data, res_row, res_col stay stable. No second sp_valid occurs until the handshake; sp_A/sp_B stay stable during WAIT.
4. start pulsed mid-run, plus ld_valid during busy → ld_ready=0, stores unchanged, result sequence unaffected, no restart.
5. Reset asserted while in EMIT at (1,2) → the next cycle shows all outputs 0 and IDLE state. A reload and start then produce a clean 16-result run from (0,0).
6. Load of A[3][3]=7 in the same cycle as start, with the rest of A = 0 and B = all 1 → C[3][*] = 7 and all other results 0.
